// File: rtl/key_pkg.sv
`default_nettype none
// ============================================================================
// Module   : key_pkg
// Purpose  : Shared key indices, issue-state encoding and command priority
//            for the Tetris button conditioner.
// Revision : 1.0  initial release
// ============================================================================
package key_pkg;

    localparam int KEY_ROTATE = 0;
    localparam int KEY_LEFT   = 1;
    localparam int KEY_RIGHT  = 2;
    localparam int KEY_DOWN   = 3;
    localparam int KEY_START  = 4;
    localparam int N_KEYS     = 5;
    localparam int N_CMDS     = 4;

    typedef enum logic [0:0] {
        ISS_IDLE = 1'b0,
        ISS_HOLD = 1'b1
    } iss_state_t;

    // Entry 0 is the highest priority: down > rotate > left > right.
    localparam logic [3:0][1:0] PRIO_ORDER = {2'(KEY_RIGHT), 2'(KEY_LEFT),
                                              2'(KEY_ROTATE), 2'(KEY_DOWN)};

    // One-hot select of the highest-priority pending command.
    function automatic logic [3:0] pick_cmd(input logic [3:0] pend);
        logic [3:0] sel;
        sel = '0;
        for (int i = 3; i >= 0; i--) begin
            if (pend[PRIO_ORDER[i]]) begin
                sel                = '0;
                sel[PRIO_ORDER[i]] = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce
// Purpose  : Two-flop synchroniser, counter debounce, rise event and optional
//            auto-repeat for one push button.
// Revision : 1.0  initial release
// ============================================================================
module key_debounce
    import key_pkg::*;
#(
    parameter int N_DEBOUNCE    = 1_000_000,
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000,
    parameter int CNT_W         = 26,
    parameter bit REPEAT_EN     = 1'b0
) (
    input  logic clk,
    input  logic clr,
    input  logic i_btn,
    output logic o_event
);

    localparam logic [CNT_W-1:0] c_DB_LAST = CNT_W'(N_DEBOUNCE - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_rise;
    logic [CNT_W-1:0] r_db_cnt;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_level  <= 1'b0;
            r_rise   <= 1'b0;
            r_db_cnt <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_rise  <= 1'b0;
            if (r_sync2 != r_level) begin
                if (r_db_cnt == c_DB_LAST) begin
                    r_level  <= r_sync2;
                    r_db_cnt <= '0;
                    r_rise   <= r_sync2;
                end else begin
                    r_db_cnt <= r_db_cnt + CNT_W'(1);
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    generate
        if (REPEAT_EN) begin : g_repeat
            localparam logic [CNT_W-1:0] c_REP_FIRST = CNT_W'(REPEAT_DELAY - 1);
            localparam logic [CNT_W-1:0] c_REP_NEXT  = CNT_W'(REPEAT_PERIOD - 1);

            logic [CNT_W-1:0] r_rep_cnt;
            logic             w_rep_hit;

            // Down-counter reaches zero exactly on each repeat cycle; a stale
            // zero left over from an earlier press is masked on the rise cycle.
            assign w_rep_hit = r_level && !r_rise && (r_rep_cnt == '0);

            always_ff @(posedge clk) begin
                if (clr) begin
                    r_rep_cnt <= '0;
                end else if (r_rise) begin
                    r_rep_cnt <= c_REP_FIRST;
                end else if (w_rep_hit) begin
                    r_rep_cnt <= c_REP_NEXT;
                end else if (r_level) begin
                    r_rep_cnt <= r_rep_cnt - CNT_W'(1);
                end
            end

            assign o_event = r_rise | w_rep_hit;
        end else begin : g_no_repeat
            assign o_event = r_rise;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/key_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : key_conditioner
// Purpose  : Debounces the five game buttons and hands movement commands to
//            the game FSM one at a time, one-hot, held until accepted.
// Revision : 1.0  initial release
// ============================================================================
module key_conditioner
    import key_pkg::*;
#(
    parameter int N_DEBOUNCE    = 1_000_000,
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000,
    parameter int CNT_W         = 26
) (
    input  logic clk,
    input  logic clr,
    input  logic btn_rotate,
    input  logic btn_left,
    input  logic btn_right,
    input  logic btn_down,
    input  logic btn_start,
    input  logic cmd_ready,
    output logic rotate,
    output logic left,
    output logic right,
    output logic down,
    output logic cmd_valid,
    output logic start
);

    logic [N_KEYS-1:0] w_btn;
    logic [N_KEYS-1:0] w_evt;

    assign w_btn = {btn_start, btn_down, btn_right, btn_left, btn_rotate};

    generate
        for (genvar k = 0; k < N_KEYS; k++) begin : g_key
            key_debounce #(
                .N_DEBOUNCE    (N_DEBOUNCE),
                .REPEAT_DELAY  (REPEAT_DELAY),
                .REPEAT_PERIOD (REPEAT_PERIOD),
                .CNT_W         (CNT_W),
                .REPEAT_EN     ((k == KEY_LEFT) || (k == KEY_RIGHT) || (k == KEY_DOWN))
            ) u_debounce (
                .clk     (clk),
                .clr     (clr),
                .i_btn   (w_btn[k]),
                .o_event (w_evt[k])
            );
        end
    endgenerate

    iss_state_t        r_state;
    iss_state_t        w_state_next;
    logic [N_CMDS-1:0] r_cmd;
    logic [N_CMDS-1:0] w_cmd_next;
    logic [N_CMDS-1:0] r_pend;
    logic [N_CMDS-1:0] w_pend_next;
    logic [N_CMDS-1:0] w_pend_clear;
    logic              w_flush;
    logic              r_start;

    assign w_flush = w_evt[KEY_START];

    always_comb begin
        w_state_next = r_state;
        w_cmd_next   = r_cmd;
        w_pend_clear = '0;
        if (w_flush) begin
            w_state_next = ISS_IDLE;
            w_cmd_next   = '0;
            w_pend_clear = '1;
        end else begin
            case (r_state)
                ISS_IDLE: begin
                    if (|r_pend) begin
                        w_cmd_next   = pick_cmd(r_pend);
                        w_pend_clear = w_cmd_next;
                        w_state_next = ISS_HOLD;
                    end
                end
                ISS_HOLD: begin
                    if (cmd_ready) begin
                        w_cmd_next   = '0;
                        w_state_next = ISS_IDLE;
                    end
                end
                default: begin
                    w_cmd_next   = '0;
                    w_state_next = ISS_IDLE;
                end
            endcase
        end
        // A new event outranks a same-cycle clear; events for the command
        // currently on the outputs are merged into it.
        w_pend_next = (r_pend & ~w_pend_clear) | (w_evt[N_CMDS-1:0] & ~r_cmd);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= ISS_IDLE;
            r_cmd   <= '0;
            r_pend  <= '0;
            r_start <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cmd   <= w_cmd_next;
            r_pend  <= w_pend_next;
            r_start <= w_evt[KEY_START];
        end
    end

    assign rotate    = r_cmd[KEY_ROTATE];
    assign left      = r_cmd[KEY_LEFT];
    assign right     = r_cmd[KEY_RIGHT];
    assign down      = r_cmd[KEY_DOWN];
    assign cmd_valid = |r_cmd;
    assign start     = r_start;

endmodule
`default_nettype wire

// File: tb/tb_key_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_conditioner
// Purpose  : Directed and random stimulus for key_conditioner, compared each
//            cycle against a behavioural model of the button rules.
// Revision : 1.0  initial release
// ============================================================================
module tb_key_conditioner;

    localparam int N_DB     = 4;
    localparam int R_DELAY  = 20;
    localparam int R_PERIOD = 8;

    logic       clk = 1'b0;
    logic       clr;
    logic [4:0] raw;
    logic       cmd_ready;
    logic       rotate, left, right, down, cmd_valid, start;

    always #5 clk = ~clk;

    key_conditioner #(
        .N_DEBOUNCE    (N_DB),
        .REPEAT_DELAY  (R_DELAY),
        .REPEAT_PERIOD (R_PERIOD),
        .CNT_W         (26)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .btn_rotate (raw[0]),
        .btn_left   (raw[1]),
        .btn_right  (raw[2]),
        .btn_down   (raw[3]),
        .btn_start  (raw[4]),
        .cmd_ready  (cmd_ready),
        .rotate     (rotate),
        .left       (left),
        .right      (right),
        .down       (down),
        .cmd_valid  (cmd_valid),
        .start      (start)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Model state: values visible during the current cycle.
    logic [4:0] m_s1, m_s2, m_lvl, m_rose;
    int         m_run   [5];
    int         m_since [5];
    logic [3:0] m_pend;
    int         m_held;
    logic       m_start;

    function automatic logic m_evt(input int k);
        logic rep;
        rep = (k >= 1) && (k <= 3) && m_lvl[k] && (m_since[k] >= R_DELAY) &&
              (((m_since[k] - R_DELAY) % R_PERIOD) == 0);
        return m_rose[k] || rep;
    endfunction

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_lvl = '0; m_rose = '0;
        for (int k = 0; k < 5; k++) begin
            m_run[k]   = 0;
            m_since[k] = 0;
        end
        m_pend  = '0;
        m_held  = -1;
        m_start = 1'b0;
    endtask

    task automatic model_step(input logic rst, input logic [4:0] r, input logic rdy);
        logic [4:0] ev;
        logic [3:0] np;
        int         nh;
        int         prio [4];
        logic       nl;
        prio = '{3, 0, 1, 2};
        for (int k = 0; k < 5; k++) ev[k] = m_evt(k);
        if (rst) begin
            model_reset();
        end else begin
            np = m_pend;
            nh = m_held;
            if (ev[4]) begin
                np = '0;
                nh = -1;
            end else if (m_held < 0) begin
                for (int i = 0; i < 4; i++) begin
                    if (nh < 0 && m_pend[prio[i]]) begin
                        nh           = prio[i];
                        np[prio[i]]  = 1'b0;
                    end
                end
            end else if (rdy) begin
                nh = -1;
            end
            for (int k = 0; k < 4; k++)
                if (ev[k] && m_held != k) np[k] = 1'b1;
            m_pend  = np;
            m_held  = nh;
            m_start = ev[4];
            for (int k = 0; k < 5; k++) begin
                nl = m_lvl[k];
                if (m_s2[k] != m_lvl[k]) begin
                    if (m_run[k] + 1 == N_DB) begin
                        nl       = m_s2[k];
                        m_run[k] = 0;
                    end else begin
                        m_run[k] = m_run[k] + 1;
                    end
                end else begin
                    m_run[k] = 0;
                end
                m_rose[k] = nl && !m_lvl[k];
                if (m_rose[k]) m_since[k] = 0;
                else if (nl)   m_since[k] = m_since[k] + 1;
                m_lvl[k] = nl;
                m_s2[k]  = m_s1[k];
                m_s1[k]  = r[k];
            end
        end
    endtask

    task automatic step(input logic rst, input logic [4:0] r, input logic rdy);
        logic [5:0] obs, exp_v;
        clr       = rst;
        raw       = r;
        cmd_ready = rdy;
        @(posedge clk);
        model_step(rst, r, rdy);
        #1;
        cyc++;
        obs   = {rotate, left, right, down, cmd_valid, start};
        exp_v = {m_held == 0, m_held == 1, m_held == 2, m_held == 3, m_held >= 0, m_start};
        n_cmp++;
        assert (obs === exp_v)
        else begin
            n_bad++;
            $error("FAIL outputs cyc=%0d {rot,lft,rgt,dwn,vld,start} observed=%b expected=%b",
                   cyc, obs, exp_v);
        end
    endtask

    task automatic hold(input logic [4:0] r, input logic rdy, input int n);
        for (int i = 0; i < n; i++) step(1'b0, r, rdy);
    endtask

    initial begin
        logic [4:0] seg_lvl;
        logic [4:0] bounce;
        logic [4:0] bounce_pat;
        logic       seg_rdy_bias;
        model_reset();
        clr = 1'b1; raw = '0; cmd_ready = 1'b0;

        // Reset state
        step(1'b1, 5'b0, 1'b0);
        step(1'b1, 5'b0, 1'b0);
        hold(5'b0, 1'b1, 4);

        // Bounce on left, then stable press
        bounce_pat = 5'b10011;
        for (int i = 0; i < 7; i++) begin
            bounce = bounce_pat;
            step(1'b0, {3'b000, (i < 2) ? 1'b1 : bounce[(i + 1) % 5], 1'b0}, 1'b1);
        end
        hold(5'b00010, 1'b1, 20);
        hold(5'b00000, 1'b1, 15);

        // Auto-repeat on down: 50 cycles held
        hold(5'b01000, 1'b1, 50);
        hold(5'b00000, 1'b1, 20);

        // Simultaneous left + down
        hold(5'b01010, 1'b1, 14);
        hold(5'b00000, 1'b1, 20);

        // Backpressure: three left presses with cmd_ready low
        for (int p = 0; p < 3; p++) begin
            hold(5'b00010, 1'b0, 12);
            hold(5'b00000, 1'b0, 12);
        end
        hold(5'b00000, 1'b0, 28);
        hold(5'b00000, 1'b1, 20);

        // Flush: right held, down pending, then start
        hold(5'b00100, 1'b0, 12);
        hold(5'b01000, 1'b0, 12);
        hold(5'b10000, 1'b0, 12);
        hold(5'b00000, 1'b1, 20);

        // Reset while holding rotate
        hold(5'b00001, 1'b0, 12);
        step(1'b1, 5'b00001, 1'b0);
        step(1'b1, 5'b00001, 1'b0);
        hold(5'b00001, 1'b0, 12);
        hold(5'b00001, 1'b1, 10);
        hold(5'b00000, 1'b1, 15);

        // Random segments with bounce noise, random backpressure and resets
        for (int s = 0; s < 80; s++) begin
            int len;
            seg_lvl      = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) != 0) seg_lvl[4] = 1'b0;
            len          = $urandom_range(1, 40);
            seg_rdy_bias = 1'($urandom_range(0, 1));
            for (int c = 0; c < len; c++) begin
                bounce = '0;
                if ($urandom_range(0, 7) == 0) bounce[$urandom_range(0, 4)] = 1'b1;
                step(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0, seg_lvl ^ bounce,
                     seg_rdy_bias ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0));
            end
        end
        hold(5'b00000, 1'b1, 30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
